// File: rtl/instr_dispatch.sv
`default_nettype none
// ============================================================================
// instr_dispatch : pops 80-bit instructions from a FWFT FIFO and issues them
// to the weight / matmul / activation units, with SYNC barrier support.
// Optional perf counters are enabled by defining DISPATCH_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
module instr_dispatch #(
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [79:0] instr_in,
  input  logic        instr_empty,
  output logic        instr_next_en,
  output logic [79:0] instr_out,
  output logic        weight_en,
  input  logic        weight_busy,
  output logic        matmul_en,
  input  logic        matmul_busy,
  output logic        act_en,
  input  logic        act_busy,
  output logic        synchronize,
  output logic        illegal_op,
  output logic        idle
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] instr_count,
  output logic [PERF_CNT_WIDTH-1:0] stall_count
`endif
);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WEIGHT = 8'h08;
  localparam logic [6:0] OP_MATMUL = 7'h10;
  localparam logic [7:0] OP_ACT    = 8'hA0;
  localparam logic [7:0] OP_SYNC   = 8'hFF;

  typedef enum logic [0:0] {
    FETCH     = 1'b0,
    SYNC_WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic [7:0] opcode;
  logic is_nop, is_weight, is_matmul, is_act, is_sync, is_illegal;
  logic busy_eff_w, busy_eff_m, busy_eff_a, all_clear, blocked;

  assign opcode     = instr_in[79:72];
  assign is_nop     = (opcode == OP_NOP);
  assign is_weight  = (opcode == OP_WEIGHT);
  assign is_matmul  = (opcode[7:1] == OP_MATMUL);
  assign is_act     = (opcode == OP_ACT);
  assign is_sync    = (opcode == OP_SYNC);
  assign is_illegal = ~(is_nop | is_weight | is_matmul | is_act | is_sync);

  // The en term covers the cycle before a unit's own busy flag rises.
  assign busy_eff_w = weight_busy | weight_en;
  assign busy_eff_m = matmul_busy | matmul_en;
  assign busy_eff_a = act_busy    | act_en;
  assign all_clear  = ~(busy_eff_w | busy_eff_m | busy_eff_a);

  assign blocked = (is_weight & busy_eff_w) | (is_matmul & busy_eff_m) |
                   (is_act & busy_eff_a);

  assign instr_next_en = (state == FETCH) & run & ~instr_empty & ~blocked;

  assign idle = (state == FETCH) & ~weight_en & ~matmul_en & ~act_en &
                ~weight_busy & ~matmul_busy & ~act_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (instr_next_en && is_sync) state_next = SYNC_WAIT;
      SYNC_WAIT: if (all_clear)                state_next = FETCH;
      default:                                 state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= '0;
      weight_en   <= 1'b0;
      matmul_en   <= 1'b0;
      act_en      <= 1'b0;
      synchronize <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      weight_en   <= instr_next_en & is_weight;
      matmul_en   <= instr_next_en & is_matmul;
      act_en      <= instr_next_en & is_act;
      synchronize <= (state == SYNC_WAIT) & all_clear;
      if (instr_next_en) instr_out <= instr_in;
      if (instr_next_en && is_illegal) illegal_op <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  // A stall is a cycle where work is available and allowed but not popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (instr_next_en) instr_count <= instr_count + 1'b1;
      if (run && !instr_empty && !instr_next_en) stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_dispatch.sv
`default_nettype none
// ============================================================================
// tb_instr_dispatch : directed self-checking bench for instr_dispatch.
// Revision: 1.0
// ============================================================================
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [79:0] instr_in = '0;
  logic        instr_empty = 1'b1;
  logic        instr_next_en;
  logic [79:0] instr_out;
  logic        weight_en, matmul_en, act_en;
  logic        weight_busy = 1'b0, matmul_busy = 1'b0, act_busy = 1'b0;
  logic        synchronize, illegal_op, idle;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] instr_count, stall_count;
`endif

  int vectors = 0;
  int errors  = 0;

  localparam logic [79:0] I_W    = 80'h08_00000010_0000_000100;
  localparam logic [79:0] I_MM1  = 80'h21_00000004_0010_000200;
  localparam logic [79:0] I_ACT  = 80'hA0_00000008_0020_000300;
  localparam logic [79:0] I_MM2  = 80'h20_00000002_0030_000400;
  localparam logic [79:0] I_SYNC = 80'hFF_00000000_0000_000000;
  localparam logic [79:0] I_ILL  = 80'h55_12345678_9ABC_DEF012;
  localparam logic [79:0] I_NOP  = 80'h00_00000000_0000_000000;

  instr_dispatch #(.PERF_CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in),
    .instr_empty(instr_empty), .instr_next_en(instr_next_en),
    .instr_out(instr_out), .weight_en(weight_en), .weight_busy(weight_busy),
    .matmul_en(matmul_en), .matmul_busy(matmul_busy), .act_en(act_en),
    .act_busy(act_busy), .synchronize(synchronize), .illegal_op(illegal_op),
    .idle(idle)
`ifdef DISPATCH_PERF_CNT_EN
    , .instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; instr_empty = 1'b1;
    weight_busy = 0; matmul_busy = 0; act_busy = 0;
    tick(); tick();
    vectors++; if (instr_out !== 80'h0) begin errors++; $display("FAIL rst_instr_out: got %h expected 0", instr_out); end
    vectors++; if ({weight_en, matmul_en, act_en} !== 3'b000) begin errors++; $display("FAIL rst_en: got %b expected 000", {weight_en, matmul_en, act_en}); end
    vectors++; if ({synchronize, illegal_op} !== 2'b00) begin errors++; $display("FAIL rst_sync_ill: got %b expected 00", {synchronize, illegal_op}); end
    vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_weight_issue();
    run = 1'b1; instr_in = I_W; instr_empty = 1'b0;
    #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL w_pop: got %b expected 1", instr_next_en); end
    tick();
    instr_empty = 1'b1; #1;
    vectors++; if (weight_en !== 1'b1) begin errors++; $display("FAIL w_en: got %b expected 1", weight_en); end
    vectors++; if (instr_out !== I_W) begin errors++; $display("FAIL w_instr_out: got %h expected %h", instr_out, I_W); end
    vectors++; if (idle !== 1'b0) begin errors++; $display("FAIL w_idle: got %b expected 0", idle); end
    vectors++; if (instr_next_en !== 1'b0) begin errors++; $display("FAIL w_pop_once: got %b expected 0", instr_next_en); end
    tick();
    vectors++; if (weight_en !== 1'b0) begin errors++; $display("FAIL w_en_pulse: got %b expected 0", weight_en); end
  endtask

  task automatic test_busy_interlock();
    weight_busy = 1'b1; instr_in = I_W; instr_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({instr_next_en, weight_en} !== 2'b00) begin errors++; $display("FAIL busy_block: got %b expected 00", {instr_next_en, weight_en}); end
      tick();
    end
    weight_busy = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL busy_release: got %b expected 1", instr_next_en); end
    tick();
    instr_empty = 1'b1; #1;
    vectors++; if (weight_en !== 1'b1) begin errors++; $display("FAIL busy_en: got %b expected 1", weight_en); end
    tick();
  endtask

  task automatic test_back_to_back();
    // c0: matmul head, all idle
    instr_in = I_MM1; instr_empty = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL b2b_pop_mm1: got %b expected 1", instr_next_en); end
    tick();
    // c1: matmul issued, activate pops same cycle
    instr_in = I_ACT; #1;
    vectors++; if (matmul_en !== 1'b1) begin errors++; $display("FAIL b2b_mm1_en: got %b expected 1", matmul_en); end
    vectors++; if (instr_out[79:72] !== 8'h21) begin errors++; $display("FAIL b2b_opcode21: got %h expected 21", instr_out[79:72]); end
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL b2b_pop_act: got %b expected 1", instr_next_en); end
    tick();
    // c2: activate issued, matmul busy now, second matmul blocked
    matmul_busy = 1'b1; instr_in = I_MM2; #1;
    vectors++; if ({act_en, matmul_en} !== 2'b10) begin errors++; $display("FAIL b2b_act_en: got %b expected 10", {act_en, matmul_en}); end
    vectors++; if (instr_out !== I_ACT) begin errors++; $display("FAIL b2b_act_out: got %h expected %h", instr_out, I_ACT); end
    vectors++; if (instr_next_en !== 1'b0) begin errors++; $display("FAIL b2b_mm2_block: got %b expected 0", instr_next_en); end
    tick();
    act_busy = 1'b1; #1;
    vectors++; if (instr_next_en !== 1'b0) begin errors++; $display("FAIL b2b_mm2_block2: got %b expected 0", instr_next_en); end
    tick();
    matmul_busy = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL b2b_mm2_pop: got %b expected 1", instr_next_en); end
    tick();
    instr_empty = 1'b1; act_busy = 1'b0; #1;
    vectors++; if (matmul_en !== 1'b1) begin errors++; $display("FAIL b2b_mm2_en: got %b expected 1", matmul_en); end
    vectors++; if (instr_out !== I_MM2) begin errors++; $display("FAIL b2b_mm2_out: got %h expected %h", instr_out, I_MM2); end
    tick(); tick();
  endtask

  task automatic test_sync();
    int pulses;
    pulses = 0;
    act_busy = 1'b1; instr_in = I_SYNC; instr_empty = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL sync_pop: got %b expected 1", instr_next_en); end
    tick();
    instr_in = I_W;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (synchronize === 1'b1) pulses++;
      vectors++; if (instr_next_en !== 1'b0) begin errors++; $display("FAIL sync_wait_nopop: got %b expected 0", instr_next_en); end
      tick();
    end
    act_busy = 1'b0; #1;
    vectors++; if ({synchronize, instr_next_en} !== 2'b00) begin errors++; $display("FAIL sync_fall_cycle: got %b expected 00", {synchronize, instr_next_en}); end
    tick();
    vectors++; if (synchronize !== 1'b1) begin errors++; $display("FAIL sync_pulse: got %b expected 1", synchronize); end
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL sync_next_pop: got %b expected 1", instr_next_en); end
    if (synchronize === 1'b1) pulses++;
    tick();
    instr_empty = 1'b1; #1;
    if (synchronize === 1'b1) pulses++;
    vectors++; if (weight_en !== 1'b1) begin errors++; $display("FAIL sync_after_en: got %b expected 1", weight_en); end
    tick(); tick();
    if (synchronize === 1'b1) pulses++;
    vectors++; if (pulses !== 1) begin errors++; $display("FAIL sync_pulse_count: got %0d expected 1", pulses); end
  endtask

  task automatic test_illegal_and_reset();
    int pulses;
    pulses = 0;
    instr_in = I_ILL; instr_empty = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL ill_pop: got %b expected 1", instr_next_en); end
    tick();
    instr_in = I_W; #1;
    vectors++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b expected 1", illegal_op); end
    vectors++; if ({weight_en, matmul_en, act_en} !== 3'b000) begin errors++; $display("FAIL ill_no_en: got %b expected 000", {weight_en, matmul_en, act_en}); end
    vectors++; if (instr_out !== I_ILL) begin errors++; $display("FAIL ill_out: got %h expected %h", instr_out, I_ILL); end
    tick();
    act_busy = 1'b1; instr_in = I_SYNC; #1;
    vectors++; if ({weight_en, illegal_op} !== 2'b11) begin errors++; $display("FAIL ill_sticky: got %b expected 11", {weight_en, illegal_op}); end
    tick();
    instr_in = I_W; tick(); tick();
    rst = 1'b1; #1;
    vectors++; if ({illegal_op, synchronize} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00", {illegal_op, synchronize}); end
    vectors++; if (instr_out !== 80'h0) begin errors++; $display("FAIL rst_mid_out: got %h expected 0", instr_out); end
    vectors++; if (idle !== 1'b0) begin errors++; $display("FAIL rst_mid_idle_busy: got %b expected 0", idle); end
    tick();
    rst = 1'b0; instr_empty = 1'b1; act_busy = 1'b0; #1;
    vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_mid_fetch: got %b expected 1", idle); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (synchronize === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_nosync: got %0d expected 0", pulses); end
    instr_empty = 1'b0; #1;
    vectors++; if (instr_next_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pop: got %b expected 1", instr_next_en); end
    tick();
    instr_empty = 1'b1; tick();
  endtask

`ifdef DISPATCH_PERF_CNT_EN
  task automatic test_perf_counters();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    vectors++; if ({instr_count, stall_count} !== 64'h0) begin errors++; $display("FAIL perf_reset: got %h expected 0", {instr_count, stall_count}); end
    weight_busy = 1'b1; instr_in = I_W; instr_empty = 1'b0;
    tick(); tick(); tick();
    weight_busy = 1'b0; tick();
    instr_in = I_NOP; tick(); tick(); tick();
    instr_empty = 1'b1; #1;
    vectors++; if (instr_count !== 32'd4) begin errors++; $display("FAIL perf_instr: got %0d expected 4", instr_count); end
    vectors++; if (stall_count !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", stall_count); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_weight_issue();
    test_busy_interlock();
    test_back_to_back();
    test_sync();
    test_illegal_and_reset();
`ifdef DISPATCH_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
Downstream consumer of the instruction FIFO (first-word-fall-through, 80-bit instructions).
- Pops instructions, decodes the opcode and issues each instruction to one of three execution units: weight loader, matrix-multiply control, activation control.
- Enforces per-unit busy interlocks and implements the synchronize barrier that reports completion to the host.

Parameters:
PERF_CNT_WIDTH, 32, width of the optional performance counters

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous and active-high
run  input  1  1 = dispatch permitted; 0 = no new pops (an in-progress SYNC_WAIT continues)
instr_in  input  80  FIFO head (data_out of FIFO); valid when instr_empty=0
instr_empty  input  1  FIFO empty flag
instr_next_en  output  1  pop strobe to FIFO; combinational
instr_out  output  80  registered copy of the last popped instruction, shared by all units
weight_en  output  1  one-cycle issue pulse to weight loader
weight_busy  input  1  weight loader busy
matmul_en  output  1  one-cycle issue pulse to matrix-multiply control
matmul_busy  input  1  matrix-multiply busy
act_en  output  1  one-cycle issue pulse to activation control
act_busy  input  1  activation busy
synchronize  output  1  one-cycle pulse when a SYNC barrier completes
illegal_op  output  1  sticky: an unknown opcode was popped
idle  output  1  FETCH state, no en pulse, all busy low

Behaviour:
- Instruction fields: opcode [79:72], calc_length [71:40], acc_address [39:24], buffer_address [23:0].
- Opcode decode:
  - 8'h00: NOP.
  - 8'h08: weight.
  - 7'h10 in opcode[7:1] (8'h20/8'h21; bit0 = accumulate flag, passed through in instr_out): matmul.
  - 8'hA0: activate.
  - 8'hFF: SYNC.
  - All others: illegal.
- Effective busy per unit: busy_eff_X = X_busy | X_en. The en-pulse mask covers the one-cycle gap before the unit's busy rises. Units must raise busy on the cycle after their en pulse.
- State FETCH. instr_next_en = run & ~instr_empty & ~busy_eff of the decoded target unit.
  - NOP, SYNC and illegal opcodes have no target and are never blocked.
  - On a pop edge:
    - instr_out <= instr_in.
    - The target unit's en goes high for exactly the next cycle. Pop-to-issue latency is 1 cycle.
    - NOP: nothing further.
    - Illegal: illegal_op <= 1 and stays set until reset.
    - SYNC: go to SYNC_WAIT.
- Head-of-line blocking: a blocked head instruction stalls all later instructions. No reordering.
- State SYNC_WAIT. instr_next_en = 0. When all busy_eff are 0: pulse synchronize for 1 cycle and return to FETCH. The earliest completion is the cycle after the pop when all units are idle.
- Back-to-back pops to different units are allowed on consecutive cycles. Pops to the same unit are separated by at least 2 cycles.
- instr_empty=1: no pop and no en. FIFO underflow is impossible by construction.
- run falling mid-stream: the en pulse for an already-popped instruction still fires.
- Reset, including mid-operation:
  - State returns to FETCH.
  - instr_out = 0; all en = 0; synchronize = 0; illegal_op = 0.
  - idle reflects the busy inputs.

Optional Feature:
Macro DISPATCH_PERF_CNT_EN.
- Defined: adds two output ports.
  - instr_count [PERF_CNT_WIDTH-1:0]: increments on every pop.
  - stall_count [PERF_CNT_WIDTH-1:0]: increments each cycle in which run=1, instr_empty=0 and instr_next_en=0.
  - Both reset to 0 and wrap silently.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset, then FIFO head 80'h08_00000010_0000_000100 with all busy=0 → instr_next_en=1 for one cycle; weight_en=1 the following cycle; instr_out matches; idle=0 during the pulse.
2. weight_busy held 1; head = weight instr → instr_next_en stays 0. Release busy → pop on the next cycle; weight_en 1 cycle later.
3. Stream matmul (8'h21), activate, matmul with busy inputs rising the cycle after each en → first two issue on consecutive cycles; second matmul waits until matmul_busy falls; opcode 8'h21 reaches instr_out unchanged.
4. SYNC (8'hFF) while act_busy=1 for 10 cycles → no pops during the wait; synchronize pulses exactly once, 1 cycle after act_busy falls; next instruction pops afterwards.
5. Opcode 8'h55 → popped, no en pulse, illegal_op=1 and remains 1 through later valid instructions. Assert rst mid-SYNC_WAIT → illegal_op=0, synchronize never pulses, state FETCH.
6. With DISPATCH_PERF_CNT_EN: 4 pops plus 3 blocked cycles → instr_count=4, stall_count=3.
